// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage sitting between EX and WB.
// Holds one EX->MEM entry, waits for the data-SRAM response of a load/store
// issued in EX, aligns/extends load data and hands the entry to WB with a
// valid/allowin handshake. Responses belonging to entries killed by a WB
// flush are counted and discarded when they eventually arrive.
//
// ld_type encoding (bits [119:117] of the EX->MEM bus):
//   0 none, 1 lw, 2 lb, 3 lbu, 4 lh, 5 lhu, 6 lwl, 7 lwr
module mem_stage #(
    parameter int          ES_TO_MS_BUS_WD = 153,
    parameter int          MS_TO_WS_BUS_WD = 117,
    parameter int          DROP_CNT_W      = 2,
    parameter logic [4:0]  NO_EX           = 5'h1f
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    output logic [4:0]                 MS_dest,
    output logic [31:0]                MS_dest_data,
    output logic                       ms_load_pending,
    input  logic                       WS_EX,
    input  logic                       ERET
);

    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_LW   = 3'd1;
    localparam logic [2:0] LD_LB   = 3'd2;
    localparam logic [2:0] LD_LBU  = 3'd3;
    localparam logic [2:0] LD_LH   = 3'd4;
    localparam logic [2:0] LD_LHU  = 3'd5;
    localparam logic [2:0] LD_LWL  = 3'd6;
    localparam logic [2:0] LD_LWR  = 3'd7;

    localparam logic [DROP_CNT_W-1:0] DROP_ZERO = {DROP_CNT_W{1'b0}};
    localparam logic [DROP_CNT_W-1:0] DROP_MAX  = {DROP_CNT_W{1'b1}};
    localparam logic [DROP_CNT_W-1:0] DROP_ONE  = {{(DROP_CNT_W-1){1'b0}}, 1'b1};

    // Aligns/extends the selected memory word for the load type; rt supplies
    // the bytes that lwl/lwr leave untouched.
    function automatic logic [31:0] load_align(
        input logic [2:0]  ld,
        input logic [1:0]  a,
        input logic [31:0] w,
        input logic [31:0] rt
    );
        logic [7:0]  byte_v;
        logic [15:0] half_v;
        logic [31:0] res_v;
        case (a)
            2'd0:    byte_v = w[7:0];
            2'd1:    byte_v = w[15:8];
            2'd2:    byte_v = w[23:16];
            2'd3:    byte_v = w[31:24];
            default: byte_v = 8'h00;
        endcase
        half_v = a[1] ? w[31:16] : w[15:0];
        case (ld)
            LD_LW:   res_v = w;
            LD_LB:   res_v = {{24{byte_v[7]}}, byte_v};
            LD_LBU:  res_v = {24'h000000, byte_v};
            LD_LH:   res_v = {{16{half_v[15]}}, half_v};
            LD_LHU:  res_v = {16'h0000, half_v};
            LD_LWL: begin
                case (a)
                    2'd0:    res_v = {w[7:0],  rt[23:0]};
                    2'd1:    res_v = {w[15:0], rt[15:0]};
                    2'd2:    res_v = {w[23:0], rt[7:0]};
                    default: res_v = w;
                endcase
            end
            LD_LWR: begin
                case (a)
                    2'd0:    res_v = w;
                    2'd1:    res_v = {rt[31:24], w[31:8]};
                    2'd2:    res_v = {rt[31:16], w[31:16]};
                    default: res_v = {rt[31:8],  w[31:24]};
                endcase
            end
            default: res_v = w;
        endcase
        return res_v;
    endfunction

    logic                       ms_valid_r;
    logic [ES_TO_MS_BUS_WD-1:0] ms_bus_r;
    logic                       data_buf_valid_r;
    logic [31:0]                data_buf_r;
    logic [DROP_CNT_W-1:0]      drop_cnt_r;
    logic [DROP_CNT_W-1:0]      drop_cnt_nxt_s;

    logic        flush_s;
    logic        drop_idle_s;
    logic        live_data_s;
    logic        ms_ready_go_s;
    logic        leave_s;
    logic        drop_inc_s;
    logic        drop_dec_s;
    logic        has_ex_s;
    logic [2:0]  ld_type_s;
    logic        mem_req_s;
    logic [31:0] rt_value_s;
    logic [31:0] addr_s;
    logic [31:0] load_word_s;
    logic [31:0] final_result_s;
    logic        gr_we_out_s;

    assign ld_type_s   = ms_bus_r[119:117];
    assign mem_req_s   = ms_bus_r[120];
    assign rt_value_s  = ms_bus_r[152:121];
    assign addr_s      = ms_bus_r[63:32];
    assign has_ex_s    = (ms_bus_r[76:72] != NO_EX);

    assign flush_s     = WS_EX | ERET;
    assign drop_idle_s = (drop_cnt_r == DROP_ZERO);
    // A response only belongs to the current entry once every stale one is gone.
    assign live_data_s = data_sram_data_ok & drop_idle_s;

    assign ms_ready_go_s  = ~mem_req_s | data_buf_valid_r | live_data_s;
    assign ms_allowin     = ~ms_valid_r | (ms_ready_go_s & ws_allowin);
    assign ms_to_ws_valid = ms_valid_r & ms_ready_go_s & ~flush_s;
    assign leave_s        = ms_to_ws_valid & ws_allowin;

    // Responses for a killed entry that had not been served yet will still arrive.
    assign drop_inc_s = flush_s & ms_valid_r & mem_req_s & ~data_buf_valid_r & ~live_data_s;
    assign drop_dec_s = data_sram_data_ok & ~drop_idle_s;

    // Buffered word if it already arrived, otherwise the response on the bus now.
    assign load_word_s = data_buf_valid_r ? data_buf_r : data_sram_rdata;

    // Next value of the stale-response counter (saturating up, floor at zero).
    always_comb begin
        drop_cnt_nxt_s = drop_cnt_r;
        if (drop_inc_s && !drop_dec_s) begin
            if (drop_cnt_r == DROP_MAX) begin
                drop_cnt_nxt_s = drop_cnt_r;
            end else begin
                drop_cnt_nxt_s = drop_cnt_r + DROP_ONE;
            end
        end else if (drop_dec_s && !drop_inc_s) begin
            drop_cnt_nxt_s = drop_cnt_r - DROP_ONE;
        end else begin
            drop_cnt_nxt_s = drop_cnt_r;
        end
    end

    // Final result and write enable presented to WB and to the forwarding path.
    always_comb begin
        final_result_s = addr_s;
        gr_we_out_s    = ms_bus_r[69];
        if (has_ex_s) begin
            gr_we_out_s    = 1'b0;
            final_result_s = addr_s;
        end else if (ld_type_s != LD_NONE) begin
            final_result_s = load_align(ld_type_s, addr_s[1:0], load_word_s, rt_value_s);
        end else begin
            final_result_s = addr_s;
        end
    end

    assign ms_to_ws_bus = {ms_bus_r[116:70], gr_we_out_s, ms_bus_r[68:64],
                           final_result_s, ms_bus_r[31:0]};

    assign MS_dest         = ms_bus_r[68:64] & {5{ms_valid_r}};
    assign MS_dest_data    = final_result_s;
    assign ms_load_pending = ms_valid_r & (ld_type_s != LD_NONE) & ~ms_ready_go_s;

    // Entry-valid flag: killed by flush, otherwise follows EX when MEM can accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ms_valid_r <= 1'b0;
        end else if (flush_s) begin
            ms_valid_r <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid_r <= es_to_ms_valid;
        end else begin
            ms_valid_r <= ms_valid_r;
        end
    end

    // EX->MEM bus register, loaded only for an accepted entry.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ms_bus_r <= {ES_TO_MS_BUS_WD{1'b0}};
        end else if (es_to_ms_valid && ms_allowin && !flush_s) begin
            ms_bus_r <= es_to_ms_bus;
        end else begin
            ms_bus_r <= ms_bus_r;
        end
    end

    // Holds the response of the current entry while WB is not accepting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_buf_valid_r <= 1'b0;
            data_buf_r       <= 32'h0000_0000;
        end else if (flush_s || leave_s) begin
            data_buf_valid_r <= 1'b0;
            data_buf_r       <= data_buf_r;
        end else if (ms_valid_r && mem_req_s && live_data_s && !data_buf_valid_r) begin
            data_buf_valid_r <= 1'b1;
            data_buf_r       <= data_sram_rdata;
        end else begin
            data_buf_valid_r <= data_buf_valid_r;
            data_buf_r       <= data_buf_r;
        end
    end

    // Count of responses still owed to entries that were flushed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drop_cnt_r <= DROP_ZERO;
        end else begin
            drop_cnt_r <= drop_cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed scenarios plus randomized traffic for mem_stage,
// checked against a transaction-level model (one entry slot, an in-order
// queue of SRAM responses, and a load-alignment function built from shifts).
module tb_mem_stage;

    localparam logic [4:0] NO_EX = 5'h1f;

    logic         clk;
    logic         reset;
    logic         ws_allowin;
    logic         ms_allowin;
    logic         es_to_ms_valid;
    logic [152:0] es_to_ms_bus;
    logic         ms_to_ws_valid;
    logic [116:0] ms_to_ws_bus;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic [4:0]   MS_dest;
    logic [31:0]  MS_dest_data;
    logic         ms_load_pending;
    logic         WS_EX;
    logic         ERET;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (ms_allowin),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .MS_dest           (MS_dest),
        .MS_dest_data      (MS_dest_data),
        .ms_load_pending   (ms_load_pending),
        .WS_EX             (WS_EX),
        .ERET              (ERET)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int check_cnt = 0;
    int error_cnt = 0;

    // driver intent for the next cycle
    bit           d_es_valid = 1'b0;
    logic [152:0] d_bus      = '0;
    logic [31:0]  d_data     = 32'h0;
    int           d_delay    = 0;
    bit           d_allow    = 1'b1;
    bit           d_ex       = 1'b0;
    bit           d_eret     = 1'b0;

    // model: the entry in MEM and the in-order SRAM response stream
    bit           have_mem   = 1'b0;
    logic [152:0] m_bus      = '0;
    logic [116:0] m_exp      = '0;
    bit           m_arrived  = 1'b0;
    int           m_id       = -2;
    int           next_id    = 0;
    int           sq_id[$];
    logic [31:0]  sq_data[$];
    int           sq_wait[$];

    bit           took        = 1'b0;
    logic [31:0]  last_result = 32'h0;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        check_cnt++;
        if (obs !== exp) begin
            error_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Memory semantics: byte k of the word lives at bits [8k+7:8k].
    function automatic logic [31:0] ref_load(input logic [2:0] ld, input logic [31:0] addr,
                                             input logic [31:0] w, input logic [31:0] rt);
        int          a;
        logic [31:0] ones;
        logic [31:0] sh;
        a    = int'(addr[1:0]);
        ones = 32'hFFFF_FFFF;
        case (ld)
            3'd1: return w;
            3'd2: begin sh = w >> (8 * a); return 32'($signed(sh[7:0])); end
            3'd3: begin sh = w >> (8 * a); return {24'h0, sh[7:0]}; end
            3'd4: begin sh = w >> (16 * int'(addr[1])); return 32'($signed(sh[15:0])); end
            3'd5: begin sh = w >> (16 * int'(addr[1])); return {16'h0, sh[15:0]}; end
            3'd6: return (w << (8 * (3 - a))) | (rt & (ones >> (8 * (a + 1))));
            3'd7: return (w >> (8 * a)) | (rt & ~(ones >> (8 * a)));
            default: return w;
        endcase
    endfunction

    function automatic logic [116:0] exp_wb(input logic [152:0] b, input logic [31:0] data);
        logic [116:0] r;
        r = b[116:0];
        if (b[76:72] != NO_EX) r[69] = 1'b0;
        else if (b[119:117] != 3'd0) r[63:32] = ref_load(b[119:117], b[63:32], data, b[152:121]);
        return r;
    endfunction

    function automatic logic [152:0] build_bus(input logic [2:0] ld, input bit mreq,
                                               input logic [31:0] addr, input logic [31:0] rt,
                                               input logic [4:0] exc);
        logic [152:0] b;
        b = {$urandom, $urandom, $urandom, $urandom, $urandom};
        b[152:121] = rt;
        b[120]     = mreq;
        b[119:117] = ld;
        b[76:72]   = exc;
        b[63:32]   = addr;
        return b;
    endfunction

    // One clock: drive at posedge+1, check and advance the model at negedge.
    task automatic step();
        bit flush, ready, e_valid, e_allow;
        @(posedge clk);
        #1;
        if (sq_id.size() > 0 && sq_wait[0] == 0) begin
            data_sram_data_ok = 1'b1;
            data_sram_rdata   = sq_data[0];
            if (have_mem && m_id == sq_id[0]) m_arrived = 1'b1;
            void'(sq_id.pop_front());
            void'(sq_data.pop_front());
            void'(sq_wait.pop_front());
        end else begin
            data_sram_data_ok = 1'b0;
            data_sram_rdata   = $urandom;
            if (sq_id.size() > 0) sq_wait[0] = sq_wait[0] - 1;
        end
        es_to_ms_valid = d_es_valid;
        es_to_ms_bus   = d_bus;
        ws_allowin     = d_allow;
        WS_EX          = d_ex;
        ERET           = d_eret;
        @(negedge clk);
        flush   = d_ex | d_eret;
        ready   = have_mem && (!m_bus[120] || m_arrived);
        e_valid = ready && !flush;
        e_allow = !have_mem || (ready && d_allow);
        check_val("ms_to_ws_valid", ms_to_ws_valid, e_valid);
        check_val("ms_allowin", ms_allowin, e_allow);
        check_val("ms_load_pending", ms_load_pending,
                  have_mem && m_bus[119:117] != 3'd0 && !ready);
        check_val("MS_dest", MS_dest, have_mem ? m_bus[68:64] : 5'd0);
        if (e_valid) begin
            check_val("wb_bus", ms_to_ws_bus, m_exp);
            check_val("fwd_data", MS_dest_data, m_exp[63:32]);
        end
        took = ms_to_ws_valid && d_allow;
        if (took) last_result = ms_to_ws_bus[63:32];
        if (flush || (e_valid && d_allow)) have_mem = 1'b0;
        if (d_es_valid && e_allow && !flush) begin
            have_mem  = 1'b1;
            m_bus     = d_bus;
            m_exp     = exp_wb(d_bus, d_data);
            m_arrived = 1'b0;
            m_id      = next_id;
            if (d_bus[120]) begin
                sq_id.push_back(next_id);
                sq_data.push_back(d_data);
                sq_wait.push_back(d_delay);
            end
            next_id++;
            d_es_valid = 1'b0;
        end
    endtask

    task automatic issue(input logic [2:0] ld, input bit mreq, input logic [31:0] addr,
                         input logic [31:0] rt, input logic [31:0] data, input int delay);
        d_bus      = build_bus(ld, mreq, addr, rt, NO_EX);
        d_data     = data;
        d_delay    = delay;
        d_es_valid = 1'b1;
        for (int i = 0; i < 20 && d_es_valid; i++) step();
        if (d_es_valid) begin
            check_val("issue_timeout", 1'b1, 1'b0);
            d_es_valid = 1'b0;
        end
    endtask

    task automatic wait_wb();
        took = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (took) break;
        end
        if (!took) check_val("wb_timeout", 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_val("rst_valid", ms_to_ws_valid, 1'b0);
        check_val("rst_dest", MS_dest, 5'd0);
        check_val("rst_pending", ms_load_pending, 1'b0);
        check_val("rst_allowin", ms_allowin, 1'b1);
        have_mem = 1'b0;
        sq_id.delete();
        sq_data.delete();
        sq_wait.delete();
        d_es_valid = 1'b0; d_ex = 1'b0; d_eret = 1'b0; d_allow = 1'b1;
        es_to_ms_valid = 1'b0; data_sram_data_ok = 1'b0; WS_EX = 1'b0; ERET = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic make_rand();
        int          k;
        logic [2:0]  ld;
        bit          mreq;
        logic [4:0]  exc;
        k    = int'($urandom % 10);
        exc  = NO_EX;
        ld   = 3'd0;
        mreq = 1'b0;
        if (k < 6) begin
            ld   = 3'(1 + $urandom % 7);
            mreq = 1'b1;
        end else if (k == 6) begin
            mreq = 1'b1;
        end else if (k == 9) begin
            exc = 5'($urandom % 31);
            ld  = 3'($urandom % 8);
        end
        if (mreq && sq_id.size() >= 2) begin
            mreq = 1'b0;
            ld   = 3'd0;
        end
        d_bus      = build_bus(ld, mreq, $urandom, $urandom, exc);
        d_data     = $urandom;
        d_delay    = int'($urandom % 4);
        d_es_valid = 1'b1;
    endtask

    initial begin
        int pend;
        int lat;
        reset = 1'b0; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0;
        data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0; WS_EX = 1'b0; ERET = 1'b0;
        #2;
        check_val("rst_valid", ms_to_ws_valid, 1'b0);
        check_val("rst_dest", MS_dest, 5'd0);
        check_val("rst_pending", ms_load_pending, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // lw: response two cycles after entering MEM, zero added latency
        issue(3'd1, 1'b1, 32'h0000_0100, 32'h0, 32'h8000_00F0, 2);
        pend = 0; lat = 0; took = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            lat++;
            if (took) break;
            if (ms_load_pending) pend++;
        end
        check_val("lw_result", last_result, 32'h8000_00F0);
        check_val("lw_latency", lat, 3);
        check_val("lw_pending_cycles", pend, 2);

        issue(3'd2, 1'b1, 32'h0000_0203, 32'h0, 32'h80FF_FF7F, 0); wait_wb();
        check_val("lb", last_result, 32'hFFFF_FF80);
        issue(3'd3, 1'b1, 32'h0000_0203, 32'h0, 32'h80FF_FF7F, 1); wait_wb();
        check_val("lbu", last_result, 32'h0000_0080);
        issue(3'd4, 1'b1, 32'h0000_0202, 32'h0, 32'h80FF_FF7F, 0); wait_wb();
        check_val("lh", last_result, 32'hFFFF_80FF);
        issue(3'd6, 1'b1, 32'h0000_0301, 32'h1122_3344, 32'hAABB_CCDD, 0); wait_wb();
        check_val("lwl", last_result, 32'hCCDD_3344);
        issue(3'd7, 1'b1, 32'h0000_0302, 32'h1122_3344, 32'hAABB_CCDD, 0); wait_wb();
        check_val("lwr", last_result, 32'h1122_AABB);

        // WB stalled when data arrives: buffered, released later without a new response
        d_allow = 1'b0;
        issue(3'd1, 1'b1, 32'h0000_0400, 32'h0, 32'h1234_5678, 0);
        repeat (3) step();
        d_allow = 1'b1;
        wait_wb();
        check_val("buffered", last_result, 32'h1234_5678);

        // flush while waiting: stale response dropped, next load gets its own data
        issue(3'd1, 1'b1, 32'h0000_0500, 32'h0, 32'h0000_DEAD, 3);
        step();
        d_ex = 1'b1; step(); d_ex = 1'b0;
        issue(3'd1, 1'b1, 32'h0000_0504, 32'h0, 32'h0000_0055, 0); wait_wb();
        check_val("after_flush", last_result, 32'h0000_0055);

        // entry presented in the flush cycle is refused, then taken next cycle
        d_bus = build_bus(3'd0, 1'b0, 32'h0000_0600, 32'h0, NO_EX);
        d_es_valid = 1'b1; d_eret = 1'b1; step(); d_eret = 1'b0;
        check_val("flush_refuse_dest", MS_dest, 5'd0);
        wait_wb();
        check_val("alu_pass", last_result, 32'h0000_0600);

        // reset with a full buffer
        d_allow = 1'b0;
        issue(3'd1, 1'b1, 32'h0000_0700, 32'h0, 32'h0000_0099, 0);
        repeat (2) step();
        do_reset();

        // reset with a stale response owed, then an orphan data_ok
        issue(3'd1, 1'b1, 32'h0000_0800, 32'h0, 32'h0000_AAAA, 8);
        step();
        d_ex = 1'b1; step(); d_ex = 1'b0;
        do_reset();
        sq_id.push_back(-1); sq_data.push_back(32'hBAD0_BAD0); sq_wait.push_back(0);
        repeat (2) step();
        issue(3'd1, 1'b1, 32'h0000_0900, 32'h0, 32'h0000_0066, 1); wait_wb();
        check_val("after_reset", last_result, 32'h0000_0066);

        // randomized traffic
        for (int c = 0; c < 4000; c++) begin
            int r;
            d_ex = 1'b0;
            d_eret = 1'b0;
            if (!d_es_valid) begin
                r = int'($urandom % 12);
                if (r == 0) d_ex = 1'b1;
                else if (r == 1) d_eret = 1'b1;
                else if (r < 8) make_rand();
            end
            d_allow = ($urandom % 4) != 0;
            step();
        end
        d_ex = 1'b0; d_eret = 1'b0; d_allow = 1'b1;
        for (int c = 0; c < 40 && d_es_valid; c++) step();
        repeat (20) step();

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage between the EX stage and the existing WB stage.
- Latches the EX→MEM bus and waits for the data-SRAM response of any load/store issued in EX.
- Aligns and extends load data, then presents the 117-bit MEM→WB bus with valid/allowin handshake.
- Provides forwarding/dependence info to decode and drops stale SRAM responses after a WB flush (exception or ERET).

Parameters:
- ES_TO_MS_BUS_WD, 153, width of EX→MEM bus.
- MS_TO_WS_BUS_WD, 117, width of MEM→WB bus (layout fixed below).
- DROP_CNT_W, 2, width of the stale-response counter (max 3 outstanding drops).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ws_allowin  in  1  WB can accept.
- ms_allowin  out  1  MEM can accept.
- es_to_ms_valid  in  1  EX bus valid.
- es_to_ms_bus  in  153  [116:0] same layout as MEM→WB bus (result field = effective address); [119:117] ld_type; [120] mem_req (SRAM request already handshaken in EX); [152:121] rt_value.
- ms_to_ws_valid  out  1  bus to WB valid.
- ms_to_ws_bus  out  117  rd[116:112], mfc0[111], mtc0[110], pc_error[109], BadVAddr[108:77], ex_code[76:72], eret[71], slot[70], gr_we[69], dest[68:64], result[63:32], pc[31:0].
- data_sram_data_ok  in  1  one-cycle response strobe.
- data_sram_rdata  in  32  response data.
- MS_dest  out  5  dest register, 0 when invalid.
- MS_dest_data  out  32  final result for forwarding.
- ms_load_pending  out  1  valid load still waiting for data_ok; decode must stall.
- WS_EX  in  1  exception taken in WB (flush).
- ERET  in  1  ERET in WB (flush).

Behaviour:
- Reset (reset=0, asynchronous):
  - ms_valid=0, data_buf_valid=0, drop_cnt=0, ms bus register cleared.
  - Outputs: ms_to_ws_valid=0, MS_dest=0, ms_load_pending=0.
- Flush = WS_EX | ERET, sampled at posedge.
  - Clears ms_valid.
  - If the current entry has mem_req=1 and no data received/buffered yet, drop_cnt increments.
  - An entry arriving in the same cycle as the flush is not accepted (ms_valid stays 0).
- Drop counter:
  - While drop_cnt!=0, each data_sram_data_ok decrements it and its data is discarded (never buffered).
  - Increment and decrement in the same cycle leave drop_cnt unchanged.
  - drop_cnt saturates at its maximum (design guarantees ≤3).
- Data capture:
  - With ms_valid & mem_req & drop_cnt==0, data_ok sets data_buf_valid=1 and stores rdata.
  - Buffer clears when the entry moves to WB or is flushed.
- ms_ready_go = !mem_req | data_buf_valid | (data_ok & drop_cnt==0).
  - Data arriving that cycle is used combinationally; zero added latency.
- ms_allowin = !ms_valid | (ms_ready_go & ws_allowin).
- ms_to_ws_valid = ms_valid & ms_ready_go & !flush.
- Bus register loads on es_to_ms_valid & ms_allowin; ms_valid <= es_to_ms_valid whenever ms_allowin (absent flush).
- Load alignment: a = addr[1:0], w = selected word (buffer or live rdata).
  - lb: sign-extend byte a; lbu: zero-extend byte a.
  - lh: sign-extend halfword addr[1]; lhu: zero-extend halfword addr[1].
  - lw: w.
  - lwl: a=0 {w[7:0],rt[23:0]}, a=1 {w[15:0],rt[15:0]}, a=2 {w[23:0],rt[7:0]}, a=3 w.
  - lwr: a=0 w, a=1 {rt[31:24],w[31:8]}, a=2 {rt[31:16],w[31:16]}, a=3 {rt[31:8],w[31:24]}.
  - ld_type=0 (non-load): result passes through unchanged.
- ex_code != NO_EX on the entry: gr_we forced 0 on output; result unmodified.
- Stores: mem_req=1, ld_type=0; wait for data_ok, then pass through.
- MS_dest = dest & {5{ms_valid}}.
- ms_load_pending = ms_valid & ld_type!=0 & !ms_ready_go.

Test Plan:
- lw at addr 0x100, data_ok 2 cycles after MEM entry with rdata 0x8000_00F0 → ms_to_ws_valid rises on the data_ok cycle; result 0x8000_00F0; ms_load_pending=1 for the 2 prior cycles.
- lb addr low bits 3, rdata 0x80FF_FF7F → result 0xFFFF_FF80; lbu same → 0x0000_0080; lh addr[1]=1 → 0xFFFF_80FF.
- lwl a=1, rt 0x1122_3344, rdata 0xAABB_CCDD → 0xCCDD_3344; lwr a=2 same inputs → 0x1122_AABB.
- ws_allowin=0 when data_ok arrives with rdata 0x1234_5678 → data buffered; ws_allowin=1 three cycles later → valid with 0x1234_5678; no second response needed.
- WS_EX pulse while a load waits → ms_valid=0, drop_cnt=1; next data_ok (rdata 0xDEAD) discarded; new load's data_ok 0x55 → result 0x55.
- reset asserted mid-wait (drop_cnt=1, buffer full) → all outputs 0 immediately; after release, first data_ok with no entry in MEM is ignored.
